reco_sched: RTL and testbench

//  Shares one reco datapath (out = data*rate - bias) between NUM_LANE accumulator lanes.

---
 rtl/reco_pkg.sv | 41 ++++
 rtl/reco_sched_if.sv | 27 ++
 rtl/reco_sched_rr_arbiter.sv | 37 +++
 rtl/reco_sched.sv | 100 ++++++++++
 tb/tb_reco_sched.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/reco_pkg.sv
// Shared definitions for the reco scheduler: reset values, widths and the
// reco transfer function out = data*rate - bias.
// Optional feature macro: RECO_SAT_EN (saturating arithmetic instead of wrap).
package reco_pkg;

    localparam int RECO_DW       = 32;
    localparam int RECO_RW       = 16;
    localparam int CNT_W         = 16;
    localparam logic [RECO_RW-1:0] RECO_RATE_RST = 16'd1;
    localparam logic [RECO_RW-1:0] RECO_BIAS_RST = 16'd0;

    function automatic logic [RECO_DW-1:0] reco_f(
        input logic [RECO_DW-1:0] data,
        input logic [RECO_RW-1:0] rate,
        input logic [RECO_RW-1:0] bias
    );
`ifdef RECO_SAT_EN
        logic [RECO_DW+RECO_RW-1:0] prod;
        logic [RECO_DW+RECO_RW-1:0] bias_ext;
        logic [RECO_DW+RECO_RW-1:0] diff;
        logic [RECO_DW-1:0]         res;
        prod     = {{RECO_RW{1'b0}}, data} * {{RECO_DW{1'b0}}, rate};
        bias_ext = {{RECO_DW{1'b0}}, bias};
        diff     = prod - bias_ext;
        if (prod < bias_ext) begin
            res = {RECO_DW{1'b0}};
        end else if (diff[RECO_DW+RECO_RW-1:RECO_DW] != {RECO_RW{1'b0}}) begin
            res = {RECO_DW{1'b1}};
        end else begin
            res = diff[RECO_DW-1:0];
        end
        return res;
`else
        // Only the low product bits survive, so the multiply is truncated up front.
        logic [RECO_DW-1:0] prod_lo;
        prod_lo = RECO_DW'({{RECO_RW{1'b0}}, data} * {{RECO_DW{1'b0}}, rate});
        return prod_lo - {{(RECO_DW-RECO_RW){1'b0}}, bias};
`endif
    endfunction

endpackage

// File: rtl/reco_sched_if.sv
// Lane request bus and result output bus of the reco scheduler.
// slave = scheduler side, master = lanes/downstream side.
interface reco_sched_if #(
    parameter int NUM_LANE = 4,
    parameter int DW       = 32,
    parameter int LANE_W   = 2,
    parameter int CNT_W    = 16
) ();
    logic [NUM_LANE-1:0]    lane_valid;
    logic [NUM_LANE*DW-1:0] lane_data;
    logic [NUM_LANE-1:0]    lane_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [LANE_W-1:0]      out_lane;
    logic [CNT_W-1:0]       out_cnt;

    modport slave (
        input  lane_valid, lane_data, out_ready,
        output lane_ready, out_valid, out_data, out_lane, out_cnt
    );

    modport master (
        output lane_valid, lane_data, out_ready,
        input  lane_ready, out_valid, out_data, out_lane, out_cnt
    );
endinterface

// File: rtl/reco_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr, wrapping around. Returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int NUM_LANE = 4,
    parameter int LANE_W   = 2
) (
    input  logic [NUM_LANE-1:0] req,
    input  logic [LANE_W-1:0]   ptr,
    output logic [NUM_LANE-1:0] grant,
    output logic [LANE_W-1:0]   idx
);

    // Scan lanes starting at ptr; the first requester found wins.
    always_comb begin
        logic found_s;
        int   j;
        grant   = {NUM_LANE{1'b0}};
        idx     = {LANE_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_LANE; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_LANE) begin
                j = j - NUM_LANE;
            end else begin
                j = j;
            end
            if (!found_s && req[j]) begin
                found_s  = 1'b1;
                grant[j] = 1'b1;
                idx      = LANE_W'(j);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/reco_sched.sv
// reco_sched: shares one reco datapath between NUM_LANE lanes with
// round-robin grant, per-lane rate/bias config and a valid/ready result stage.
// Optional feature macro: RECO_SAT_EN (see reco_pkg::reco_f).
module reco_sched
    import reco_pkg::*;
#(
    parameter int bitwidth      = RECO_DW,
    parameter int inputBitwidth = RECO_RW,
    parameter int NUM_LANE      = 4,
    parameter int LANE_W        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     cfg_we,
    input  logic [LANE_W-1:0]        cfg_lane,
    input  logic [inputBitwidth-1:0] cfg_rate,
    input  logic [inputBitwidth-1:0] cfg_bias,
    reco_sched_if.slave              bus
);

    logic [inputBitwidth-1:0] rate_r [NUM_LANE];
    logic [inputBitwidth-1:0] bias_r [NUM_LANE];
    logic [LANE_W-1:0]        ptr_r;
    logic                     out_valid_r;
    logic [bitwidth-1:0]      out_data_r;
    logic [LANE_W-1:0]        out_lane_r;
    logic [CNT_W-1:0]         out_cnt_r;

    logic [NUM_LANE-1:0]      grant_s;
    logic [LANE_W-1:0]        gidx_s;
    logic                     accept_s;
    logic                     any_s;
    logic [bitwidth-1:0]      sel_data_s;
    logic [bitwidth-1:0]      result_s;

    rr_arbiter #(
        .NUM_LANE (NUM_LANE),
        .LANE_W   (LANE_W)
    ) u_arb (
        .req   (bus.lane_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    // Accept decision, lane handshake and the shared datapath for the granted lane.
    always_comb begin
        accept_s       = enable & (~out_valid_r | bus.out_ready);
        any_s          = |grant_s;
        bus.lane_ready = grant_s & {NUM_LANE{accept_s & rst_n}};
        sel_data_s     = bus.lane_data[int'(gidx_s)*bitwidth +: bitwidth];
        result_s       = reco_f(sel_data_s, rate_r[gidx_s], bias_r[gidx_s]);
    end

    // Per-lane config registers; a write is visible from the next cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANE; i++) begin
                rate_r[i] <= RECO_RATE_RST;
                bias_r[i] <= RECO_BIAS_RST;
            end
        end else if (cfg_we) begin
            rate_r[cfg_lane] <= cfg_rate;
            bias_r[cfg_lane] <= cfg_bias;
        end
    end

    // Result register and round-robin pointer; output holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {bitwidth{1'b0}};
            out_lane_r  <= {LANE_W{1'b0}};
            ptr_r       <= {LANE_W{1'b0}};
        end else if (accept_s && any_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_lane_r  <= gidx_s;
            ptr_r       <= (gidx_s == LANE_W'(NUM_LANE-1)) ? {LANE_W{1'b0}} : gidx_s + LANE_W'(1);
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Count results taken by the downstream stage; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && bus.out_ready) begin
            out_cnt_r <= out_cnt_r + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_lane  = out_lane_r;
    assign bus.out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_reco_sched.sv
// Directed, table-driven bench for reco_sched.
module tb_reco_sched;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cfg_we;
    logic [1:0]  cfg_lane;
    logic [15:0] cfg_rate;
    logic [15:0] cfg_bias;

    int checks;
    int errors;

`ifdef RECO_SAT_EN
    localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFF;
`endif

    reco_sched_if #(.NUM_LANE(4), .DW(32), .LANE_W(2), .CNT_W(16)) bus ();

    reco_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .cfg_we   (cfg_we),
        .cfg_lane (cfg_lane),
        .cfg_rate (cfg_rate),
        .cfg_bias (cfg_bias),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ordy;
        logic [3:0]  valid;
        logic [127:0] data;
        logic        cw;
        logic [1:0]  cl;
        logic [15:0] cr;
        logic [15:0] cb;
        logic [3:0]  exp_lr;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_ol;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic en, input logic ordy, input logic [3:0] valid,
                                input logic [127:0] data, input logic cw, input logic [1:0] cl,
                                input logic [15:0] cr, input logic [15:0] cb, input logic [3:0] lr,
                                input logic ov, input logic [31:0] od, input logic [1:0] ol,
                                input logic [15:0] cnt);
        vec_t v;
        v.en = en; v.ordy = ordy; v.valid = valid; v.data = data;
        v.cw = cw; v.cl = cl; v.cr = cr; v.cb = cb;
        v.exp_lr = lr; v.exp_ov = ov; v.exp_od = od; v.exp_ol = ol; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one vector at posedge+1, checks lane_ready, then checks registered outputs after the edge.
    task automatic run_vec(input int n, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", n);
        enable         = v.en;
        bus.out_ready  = v.ordy;
        bus.lane_valid = v.valid;
        bus.lane_data  = v.data;
        cfg_we   = v.cw;
        cfg_lane = v.cl;
        cfg_rate = v.cr;
        cfg_bias = v.cb;
        #1;
        check({tag, " lane_ready"}, {28'd0, bus.lane_ready}, {28'd0, v.exp_lr});
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, v.exp_ov});
        check({tag, " out_data"}, bus.out_data, v.exp_od);
        check({tag, " out_lane"}, {30'd0, bus.out_lane}, {30'd0, v.exp_ol});
        check({tag, " out_cnt"}, {16'd0, bus.out_cnt}, {16'd0, v.exp_cnt});
    endtask

    initial begin
        logic [127:0] all_rot;
        logic [127:0] all4;
        checks = 0;
        errors = 0;
        all_rot = {32'd103, 32'd102, 32'd101, 32'd100};
        all4    = {32'd4, 32'd4, 32'd4, 32'd4};

        // Basic, config, wrap/sat boundary
        vecs[0]  = mk(1'b1, 1'b1, 4'b0001, {96'd0, 32'd7}, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0001, 1'b1, 32'd7, 2'd0, 16'd0);
        vecs[1]  = mk(1'b1, 1'b1, 4'b0000, 128'd0, 1'b1, 2'd2, 16'd3, 16'd5, 4'b0000, 1'b0, 32'd7, 2'd0, 16'd1);
        vecs[2]  = mk(1'b1, 1'b1, 4'b0100, {32'd0, 32'd10, 64'd0}, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0100, 1'b1, 32'd25, 2'd2, 16'd1);
        vecs[3]  = mk(1'b1, 1'b1, 4'b0000, 128'd0, 1'b1, 2'd3, 16'd1, 16'd2, 4'b0000, 1'b0, 32'd25, 2'd2, 16'd2);
        vecs[4]  = mk(1'b1, 1'b1, 4'b1000, {32'd1, 96'd0}, 1'b0, 2'd0, 16'd0, 16'd0, 4'b1000, 1'b1, EXP_NEG, 2'd3, 16'd2);
        // All lanes requesting: strict rotation
        vecs[5]  = mk(1'b1, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0001, 1'b1, 32'd100, 2'd0, 16'd3);
        vecs[6]  = mk(1'b1, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0010, 1'b1, 32'd101, 2'd1, 16'd4);
        vecs[7]  = mk(1'b1, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0100, 1'b1, 32'd301, 2'd2, 16'd5);
        vecs[8]  = mk(1'b1, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b1000, 1'b1, 32'd101, 2'd3, 16'd6);
        vecs[9]  = mk(1'b1, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0001, 1'b1, 32'd100, 2'd0, 16'd7);
        // Backpressure: output held, no grants
        vecs[10] = mk(1'b1, 1'b0, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0000, 1'b1, 32'd100, 2'd0, 16'd7);
        vecs[11] = mk(1'b1, 1'b0, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0000, 1'b1, 32'd100, 2'd0, 16'd7);
        vecs[12] = mk(1'b1, 1'b0, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0000, 1'b1, 32'd100, 2'd0, 16'd7);
        vecs[13] = mk(1'b1, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0010, 1'b1, 32'd101, 2'd1, 16'd8);
        // enable low: drain only
        vecs[14] = mk(1'b0, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0000, 1'b0, 32'd101, 2'd1, 16'd9);
        vecs[15] = mk(1'b0, 1'b1, 4'b1111, all_rot, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0000, 1'b0, 32'd101, 2'd1, 16'd9);
        // Config write same cycle as grant uses old rate
        vecs[16] = mk(1'b1, 1'b1, 4'b0010, all4, 1'b1, 2'd1, 16'd2, 16'd0, 4'b0010, 1'b1, 32'd4, 2'd1, 16'd9);
        vecs[17] = mk(1'b1, 1'b1, 4'b0010, all4, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0010, 1'b1, 32'd8, 2'd1, 16'd10);
        // After mid-stream reset: ptr=0, config back to defaults
        vecs[18] = mk(1'b1, 1'b1, 4'b1111, all4, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0001, 1'b1, 32'd4, 2'd0, 16'd0);
        vecs[19] = mk(1'b1, 1'b1, 4'b0100, {32'd0, 32'd10, 64'd0}, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0100, 1'b1, 32'd10, 2'd2, 16'd1);
        vecs[20] = mk(1'b1, 1'b1, 4'b0010, all4, 1'b0, 2'd0, 16'd0, 16'd0, 4'b0010, 1'b1, 32'd4, 2'd1, 16'd2);

        // Reset with requests present
        rst_n = 1'b0;
        enable = 1'b1;
        cfg_we = 1'b0; cfg_lane = 2'd0; cfg_rate = 16'd0; cfg_bias = 16'd0;
        bus.out_ready  = 1'b1;
        bus.lane_valid = 4'b1111;
        bus.lane_data  = all4;
        repeat (2) @(posedge clk);
        #1;
        check("rst lane_ready", {28'd0, bus.lane_ready}, 32'd0);
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst out_data", bus.out_data, 32'd0);
        check("rst out_lane", {30'd0, bus.out_lane}, 32'd0);
        check("rst out_cnt", {16'd0, bus.out_cnt}, 32'd0);
        bus.lane_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 18; n++) begin
            run_vec(n, vecs[n]);
        end

        // Asynchronous reset mid-stream: outputs clear immediately
        bus.lane_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("midrst lane_ready", {28'd0, bus.lane_ready}, 32'd0);
        check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst out_data", bus.out_data, 32'd0);
        check("midrst out_lane", {30'd0, bus.out_lane}, 32'd0);
        check("midrst out_cnt", {16'd0, bus.out_cnt}, 32'd0);
        bus.lane_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 18; n < 21; n++) begin
            run_vec(n, vecs[n]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
